// File: rtl/aes_encryption.sv
// Fully unrolled AES-128 encryptor: one round per pipeline stage, one block per clock.
// Optional AES_VALID_EN adds out_valid, which marks the end of pipeline fill after reset.
module aes_encryption (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] Data_in,
  input  logic [127:0] key_in,
  output logic [127:0] cipher_out
`ifdef AES_VALID_EN
  ,
  output logic         out_valid
`endif
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127, inv;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    inv  = gf_mul(x127, x127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int i = 0; i < 16; i++) begin
      o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    end
    return o;
  endfunction

  // Byte index is 4*col+row; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] st_d [10];
  logic [127:0] st_q [10];
  logic [127:0] rk_d [10];
  logic [127:0] rk_q [10];
  logic [127:0] cipher_d, cipher_q;

  // Round logic: each stage derives its round key from the key register travelling beside it.
  always_comb begin
    st_d[0] = Data_in ^ key_in;
    rk_d[0] = key_in;
    for (int r = 1; r < 10; r++) begin
      rk_d[r] = key_exp(rk_q[r-1], rcon(r[3:0]));
      st_d[r] = mix_columns(shift_rows(sub_bytes(st_q[r-1]))) ^ rk_d[r];
    end
    cipher_d = shift_rows(sub_bytes(st_q[9])) ^ key_exp(rk_q[9], rcon(4'd10));
  end

  // Data and key pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++) begin
        st_q[i] <= 128'h0;
        rk_q[i] <= 128'h0;
      end
      cipher_q <= 128'h0;
    end else begin
      st_q     <= st_d;
      rk_q     <= rk_d;
      cipher_q <= cipher_d;
    end
  end

  assign cipher_out = cipher_q;

`ifdef AES_VALID_EN
  logic [10:0] valid_sr_d, valid_sr_q;

  // A one walks through eleven stages, matching the datapath depth.
  always_comb begin
    valid_sr_d = {valid_sr_q[9:0], 1'b1};
  end

  // Fill tracker register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr_q <= 11'h000;
    end else begin
      valid_sr_q <= valid_sr_d;
    end
  end

  assign out_valid = valid_sr_q[10];
`endif

endmodule

// File: tb/tb_aes_encryption.sv
// Directed bench for aes_encryption: known FIPS-197 vectors through a latency scoreboard,
// including a mid-stream asynchronous reset.
module tb_aes_encryption;

  logic         clk;
  logic         rst_n;
  logic [127:0] data_in;
  logic [127:0] key_in;
  logic [127:0] cipher_out;
`ifdef AES_VALID_EN
  logic         out_valid;
`endif

  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Z  = 128'h0;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_encryption dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Data_in    (data_in),
    .key_in     (key_in),
    .cipher_out (cipher_out)
`ifdef AES_VALID_EN
    ,
    .out_valid  (out_valid)
`endif
  );

  logic [127:0] sbq [$];
  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_valid(input logic exp);
`ifdef AES_VALID_EN
    check("out_valid", {127'h0, out_valid}, {127'h0, exp});
`endif
  endtask

  // Drive one input pair, record its expected ciphertext, and compare whatever is due.
  task automatic cycle(input logic [127:0] d, input logic [127:0] k, input logic [127:0] e);
    logic [127:0] x;
    data_in = d;
    key_in  = k;
    sbq.push_back(e);
    @(negedge clk);
    edge_cnt++;
    if (sbq.size() == 11) begin
      x = sbq.pop_front();
      check("cipher", cipher_out, x);
    end
    check_valid(edge_cnt >= 11);
  endtask

  initial begin
    rst_n   = 1'b0;
    data_in = P1;
    key_in  = K1;
    repeat (3) @(negedge clk);
    check("reset_cipher", cipher_out, Z);
    check_valid(1'b0);

    rst_n    = 1'b1;
    edge_cnt = 0;
    sbq.delete();
    repeat (14) cycle(P1, K1, C1);
    repeat (3) cycle(P2, K2, C2);
    repeat (3) cycle(Z, Z, C3);
    for (int i = 0; i < 3; i++) begin
      cycle(P1, K1, C1);
      cycle(P2, K2, C2);
      cycle(Z, Z, C3);
    end
    repeat (11) cycle(Z, Z, C3);

    for (int i = 0; i < 2; i++) begin
      cycle(P1, K1, C1);
      cycle(P2, K2, C2);
      cycle(Z, Z, C3);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_cipher", cipher_out, Z);
    check_valid(1'b0);
    sbq.delete();
    data_in = P1;
    key_in  = K1;
    repeat (2) @(negedge clk);
    check("held_reset_cipher", cipher_out, Z);
    check_valid(1'b0);

    rst_n    = 1'b1;
    edge_cnt = 0;
    repeat (12) cycle(P1, K1, C1);
    repeat (11) cycle(Z, Z, C3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
